// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch/issue/RS-status bundle for the instruction queue
// The queue uses the slave modport; the fetch/RS side uses master.
interface instr_queue_if #(
  parameter int DEPTH = 8
);
  logic                     in_valid;
  logic [31:0]              in_instr;
  logic                     in_ready;
  logic                     add_full;
  logic                     mul_full;
  logic                     flush;
  logic [31:0]              instr_out;
  logic                     issue_valid;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_instr, add_full, mul_full, flush,
    input  in_ready, instr_out, issue_valid, count
  );

  modport slave (
    input  in_valid, in_instr, add_full, mul_full, flush,
    output in_ready, instr_out, issue_valid, count
  );
endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - in-order circular instruction queue feeding the decoder
// Issues the head only when its target reservation station has room, else drives NOP.
module instr_queue #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic         clk,
  input  logic         reset,
  instr_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr_out;
  logic          r_issue_valid;

  logic [31:0]   w_head;
  logic          w_is_mul;
  logic          w_rs_full;
  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_is_mul   = (w_head[6:0] == 7'b0110011) && (w_head[31:25] == 7'b0000001);
  assign w_rs_full  = w_is_mul ? bus.mul_full : bus.add_full;
  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = bus.in_valid && w_in_ready && !bus.flush;
  // A blocked head stalls everything behind it; there is no bypass.
  assign w_pop      = (r_count != '0) && !bus.flush && !w_rs_full;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= bus.in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_instr_out   <= NOP;
      r_issue_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + 1'b1;
        r_instr_out   <= w_head;
        r_issue_valid <= 1'b1;
      end else begin
        r_instr_out   <= NOP;
        r_issue_valid <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.instr_out   = r_instr_out;
  assign bus.issue_valid = r_issue_valid;
  assign bus.count       = r_count;
endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard bench for instr_queue
// Stimulus feeds a reference queue; a negedge monitor compares each DUT issue against it.
module tb_instr_queue;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_queue_if #(.DEPTH(DEPTH)) bus ();
  instr_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;

  function automatic bit is_mul(logic [31:0] i);
    return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    bit          pop, push, clr;
    logic [31:0] h, din;
    pop  = (mq.size() != 0) && !bus.flush && !reset &&
           !(is_mul(mq[0]) ? bus.mul_full : bus.add_full);
    push = bus.in_valid && (mq.size() < DEPTH) && !bus.flush && !reset;
    clr  = reset || bus.flush;
    din  = bus.in_instr;
    @(posedge clk);
    if (clr) begin
      mq.delete();
    end else begin
      if (pop) begin
        h = mq.pop_front();
        exp_q.push_back(h);
      end
      if (push) mq.push_back(din);
    end
    #1;
  endtask

  task automatic push1(logic [31:0] i);
    bus.in_valid = 1'b1;
    bus.in_instr = i;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    for (int k = 0; k < 40 && mq.size() != 0; k++) cyc();
    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries still queued, required 0", name, mq.size());
    end
    cyc();
    cyc();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(bus.count), 32'(mq.size()));
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      if (bus.issue_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_issue: got %h expected no issue at %0t", bus.instr_out, $time);
        end else begin
          check("issue", bus.instr_out, exp_q.pop_front());
        end
      end else begin
        check("nop", bus.instr_out, NOP);
        if (exp_q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL missing_issue: got no issue expected %h at %0t", exp_q[0], $time);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.add_full = 1'b0;
    bus.mul_full = 1'b0;
    bus.flush    = 1'b0;
    reset        = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_instr_out", bus.instr_out, NOP);
    check("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    mon_en = 1'b1;

    // 1: single ADD passes straight through
    push1(32'h002081B3);
    check("t1_count_after_push", 32'(bus.count), 32'd1);
    cyc();
    check("t1_issue", bus.instr_out, 32'h002081B3);
    check("t1_count_after_issue", 32'(bus.count), 32'd0);
    drain("t1");

    // 2: blocked MUL head holds the younger ADD behind it
    bus.mul_full = 1'b1;
    push1(32'h022081B3);
    push1(32'h00418233);
    cyc();
    cyc();
    check("t2_blocked_out", bus.instr_out, NOP);
    check("t2_blocked_count", 32'(bus.count), 32'd2);
    bus.mul_full = 1'b0;
    drain("t2");

    // 3: fill to DEPTH; a ninth instruction is refused
    bus.add_full = 1'b1;
    for (int k = 0; k < DEPTH; k++) push1(32'h00000093 | (32'(k + 1) << 20));
    check("t3_full_count", 32'(bus.count), 32'd8);
    check("t3_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00900093;
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    check("t3_still_full", 32'(bus.count), 32'd8);
    bus.add_full = 1'b0;
    drain("t3");

    // 4: continuous stream across the pointer wrap
    for (int k = 0; k < 13; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00208033 | (32'(k + 1) << 7);
      cyc();
    end
    bus.in_valid = 1'b0;
    drain("t4");

    // 5: flush beats a simultaneous push
    bus.add_full = 1'b1;
    push1(32'h00100113);
    push1(32'h00200113);
    push1(32'h00300113);
    check("t5_pre_count", 32'(bus.count), 32'd3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00400113;
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_flush_count", 32'(bus.count), 32'd0);
    check("t5_flush_out", bus.instr_out, NOP);
    check("t5_flush_valid", 32'(bus.issue_valid), 32'd0);
    bus.add_full = 1'b0;
    cyc();
    cyc();

    // 6: reset while issuing, then the queue restarts cleanly
    bus.add_full = 1'b1;
    for (int k = 0; k < 6; k++) push1(32'h00000513 | (32'(k + 1) << 20));
    bus.add_full = 1'b0;
    cyc();
    check("t6_pre_count", 32'(bus.count), 32'd5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_reset_count", 32'(bus.count), 32'd0);
    check("t6_reset_out", bus.instr_out, NOP);
    push1(32'h00A00513);
    cyc();
    check("t6_first_issue", bus.instr_out, 32'h00A00513);
    drain("t6");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
